// File: rtl/vz_load_ctrl.sv
// vz_load_ctrl
//   Streams a VZ image from the hps_io ioctl download into system RAM.
//   Parses the VZ header (magic, type, start address), buffers payload
//   bytes in a small FIFO and writes them to RAM whenever the Z80 leaves
//   the RAM port idle. The Z80 always has priority.
//
//   Optional build macro VZ_PATCH_EN: after a type F0 (BASIC) load, the
//   BASIC end-of-program pointer at PTR_ADDR is rewritten with
//   vz_start + payload length.
//
// Ports
//   CLK10MHZ, RESET           10 MHz system clock, async active-low reset
//   dn_download/wr/addr/data/index, dn_wait   hps_io ioctl stream
//   cpu_ram_req               Z80 owns RAM this cycle
//   ram_we/addr/wdata         loader write port into the RAM mux
//   load_busy/done/err        load status (done/err sticky until next load)
//   vz_type, vz_start         header fields of the current/last load
module vz_load_ctrl #(
   parameter logic [7:0]  VZ_INDEX   = 8'd1,
   parameter int          FIFO_DEPTH = 4,
   parameter int          HDR_LEN    = 24,
   parameter logic [15:0] PTR_ADDR   = 16'h78F9
) (
   input  logic        CLK10MHZ,
   input  logic        RESET,
   input  logic        dn_download,
   input  logic        dn_wr,
   input  logic [15:0] dn_addr,
   input  logic [7:0]  dn_data,
   input  logic [7:0]  dn_index,
   output logic        dn_wait,
   input  logic        cpu_ram_req,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_wdata,
   output logic        load_busy,
   output logic        load_done,
   output logic        load_err,
   output logic [7:0]  vz_type,
   output logic [15:0] vz_start
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      IDLE, HEADER, DATA, DRAIN, PATCH_LO, PATCH_HI, DONE, ERR
   } state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } fifo_ent_t;

   state_t            state;
   fifo_ent_t         fifo_mem [FIFO_DEPTH];
   fifo_ent_t         head;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              act, act_q, act_rise, act_fall;
   logic              fifo_full, push, pop;
   logic              magic_vz, magic_sp;
   logic [7:0]        vz_byte, sp_byte;
   logic [15:0]       push_addr;

   assign act       = dn_download && (dn_index == VZ_INDEX);
   assign act_rise  = act && !act_q;
   assign act_fall  = !act && act_q;
   assign fifo_full = (count == CW'(FIFO_DEPTH));
   assign dn_wait   = (count >= CW'(FIFO_DEPTH - 1));
   assign head      = fifo_mem[rd_ptr];
   // 16-bit wrap is intentional: images may run past FFFF into 0000.
   assign push_addr = vz_start + (dn_addr - 16'(HDR_LEN));

   // Bytes that overflow a full FIFO are dropped here and flagged below.
   assign push = (state == DATA) && act && dn_wr && !fifo_full;
   // Pop decision uses this cycle's Z80 request; the write itself is
   // presented from registers on the following cycle.
   assign pop  = ((state == DATA) || (state == DRAIN)) && !cpu_ram_req &&
                 (count != '0);

`ifdef VZ_PATCH_EN
   logic [15:0] payload_cnt;
   logic [15:0] end_ptr;
   assign end_ptr = vz_start + payload_cnt;
`endif

   always_comb begin
      vz_byte = 8'h56;
      sp_byte = 8'h20;
      case (dn_addr[1:0])
         2'd0: begin vz_byte = 8'h56; sp_byte = 8'h20; end
         2'd1: begin vz_byte = 8'h5A; sp_byte = 8'h20; end
         2'd2: begin vz_byte = 8'h46; sp_byte = 8'h00; end
         default: begin vz_byte = 8'h30; sp_byte = 8'h00; end
      endcase
   end

   // FIFO storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge CLK10MHZ) begin
      if (push) fifo_mem[wr_ptr] <= '{addr: push_addr, data: dn_data};
   end

   always_ff @(posedge CLK10MHZ or negedge RESET) begin
      if (!RESET) begin
         state     <= IDLE;
         act_q     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         magic_vz  <= 1'b0;
         magic_sp  <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         load_busy <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         vz_type   <= '0;
         vz_start  <= '0;
`ifdef VZ_PATCH_EN
         payload_cnt <= '0;
`endif
      end else begin
         act_q  <= act;
         ram_we <= pop;
         if (pop) begin
            ram_addr  <= head.addr;
            ram_wdata <= head.data;
            rd_ptr    <= rd_ptr + 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
`ifdef VZ_PATCH_EN
         if (push) payload_cnt <= payload_cnt + 1'b1;
`endif

         case (state)
            IDLE: if (act_rise) begin
               load_done <= 1'b0;
               load_err  <= 1'b0;
               load_busy <= 1'b1;
               magic_vz  <= 1'b1;
               magic_sp  <= 1'b1;
`ifdef VZ_PATCH_EN
               payload_cnt <= '0;
`endif
               state     <= HEADER;
            end
            HEADER: begin
               if (act_fall) begin
                  // Download ended inside the header: truncated image.
                  load_err <= 1'b1;
                  state    <= ERR;
               end else if (act && dn_wr) begin
                  if (dn_addr < 16'd4) begin
                     if (dn_data != vz_byte) magic_vz <= 1'b0;
                     if (dn_data != sp_byte) magic_sp <= 1'b0;
                  end
                  if (dn_addr == 16'd21) vz_type       <= dn_data;
                  if (dn_addr == 16'd22) vz_start[7:0]  <= dn_data;
                  if (dn_addr == 16'd23) vz_start[15:8] <= dn_data;
                  if (dn_addr == 16'(HDR_LEN - 1)) begin
                     if (magic_vz || magic_sp) begin
                        state <= DATA;
                     end else begin
                        load_err <= 1'b1;
                        state    <= ERR;
                     end
                  end
               end
            end
            DATA: begin
               // Overflow is a sender protocol fault; keep loading.
               if (act && dn_wr && fifo_full) load_err <= 1'b1;
               if (act_fall) state <= DRAIN;
            end
            DRAIN: if (count == '0) begin
`ifdef VZ_PATCH_EN
               state <= (vz_type == 8'hF0) ? PATCH_LO : DONE;
`else
               state <= DONE;
`endif
            end
`ifdef VZ_PATCH_EN
            PATCH_LO: if (!cpu_ram_req) begin
               ram_we    <= 1'b1;
               ram_addr  <= PTR_ADDR;
               ram_wdata <= end_ptr[7:0];
               state     <= PATCH_HI;
            end
            PATCH_HI: if (!cpu_ram_req) begin
               ram_we    <= 1'b1;
               ram_addr  <= PTR_ADDR + 16'd1;
               ram_wdata <= end_ptr[15:8];
               state     <= DONE;
            end
`endif
            DONE: begin
               load_done <= 1'b1;
               load_busy <= 1'b0;
               state     <= IDLE;
            end
            ERR: begin
               load_busy <= 1'b0;
               count     <= '0;
               rd_ptr    <= wr_ptr;
               if (!act) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vz_load_ctrl.sv
module tb_vz_load_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dn_download = 1'b0, dn_wr = 1'b0;
   logic [15:0] dn_addr = '0;
   logic [7:0]  dn_data = '0, dn_index = '0;
   logic        dn_wait, cpu_ram_req = 1'b0;
   logic        ram_we, load_busy, load_done, load_err;
   logic [15:0] ram_addr, vz_start;
   logic [7:0]  ram_wdata, vz_type;

   int tests = 0, fails = 0, bad_we = 0;
   logic [23:0] wq [$];

   vz_load_ctrl dut (
      .CLK10MHZ(clk), .RESET(rst_n),
      .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr),
      .dn_data(dn_data), .dn_index(dn_index), .dn_wait(dn_wait),
      .cpu_ram_req(cpu_ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .load_busy(load_busy), .load_done(load_done),
      .load_err(load_err), .vz_type(vz_type), .vz_start(vz_start)
   );

   always #50 clk = ~clk;

   // Write log, sampled away from the active edge.
   always @(negedge clk) begin
      if (ram_we) wq.push_back({ram_addr, ram_wdata});
      if (ram_we && cpu_ram_req) bad_we++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit honor);
      int n;
      n = 0;
      while (honor && dn_wait && n < 100) begin tick(); n++; end
      if (n >= 100) begin
         tests++; fails++;
         $display("FAIL send_wait: dn_wait=%0b after 100 cycles, required 0", dn_wait);
      end
      dn_addr = a; dn_data = d; dn_wr = 1'b1;
      tick();
      dn_wr = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] magic, input logic [7:0] typ, input logic [15:0] start);
      logic [7:0] b;
      for (int i = 0; i < 24; i++) begin
         b = 8'h00;
         if (i < 4)   b = magic[8*(3-i) +: 8];
         if (i == 21) b = typ;
         if (i == 22) b = start[7:0];
         if (i == 23) b = start[15:8];
         send_byte(16'(i), b, 1'b1);
      end
   endtask

   task automatic start_dl();
      wq.delete();
      dn_index = 8'd1; dn_download = 1'b1;
      tick(); tick();
   endtask

   task automatic end_dl();
      int n;
      dn_download = 1'b0;
      n = 0;
      while (load_busy && n < 200) begin tick(); n++; end
      if (n >= 200) begin
         tests++; fails++;
         $display("FAIL end_dl: load_busy=%0b after 200 cycles, required 0", load_busy);
      end
      tick(); tick();
   endtask

   task automatic test_reset();
      tick(); tick();
      tests++;
      if ({dn_wait, ram_we, load_busy, load_done, load_err} !== 5'b0) begin
         fails++; $display("FAIL reset_flags: got %b, want 00000", {dn_wait, ram_we, load_busy, load_done, load_err});
      end
      tests++;
      if ({ram_addr, ram_wdata, vz_type, vz_start} !== 48'h0) begin
         fails++; $display("FAIL reset_regs: got %h, want 0", {ram_addr, ram_wdata, vz_type, vz_start});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [23:0] exp [$];
      exp = '{24'h8000AA, 24'h8001BB, 24'h8002CC};
      start_dl();
      tests++;
      if (load_busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b, want 1", load_busy); end
      send_hdr(32'h565A4630, 8'hF1, 16'h8000);
      send_byte(16'd24, 8'hAA, 1'b1);
      tests++;
      if (ram_we !== 1'b0) begin fails++; $display("FAIL basic_lat1: ram_we=%b one cycle after dn_wr, want 0", ram_we); end
      send_byte(16'd25, 8'hBB, 1'b1);
      tests++;
      if (ram_we !== 1'b1 || ram_addr !== 16'h8000) begin
         fails++; $display("FAIL basic_lat2: ram_we=%b addr=%h, want 1 8000", ram_we, ram_addr);
      end
      send_byte(16'd26, 8'hCC, 1'b1);
      end_dl();
      tests++;
      if (wq.size() != exp.size()) begin fails++; $display("FAIL basic_count: got %0d writes, want %0d", wq.size(), exp.size()); end
      else for (int i = 0; i < exp.size(); i++) begin
         tests++;
         if (wq[i] !== exp[i]) begin fails++; $display("FAIL basic_wr%0d: got %h, want %h", i, wq[i], exp[i]); end
      end
      tests++;
      if ({load_done, load_err, load_busy} !== 3'b100) begin
         fails++; $display("FAIL basic_status: got done/err/busy=%b, want 100", {load_done, load_err, load_busy});
      end
      tests++;
      if (vz_start !== 16'h8000 || vz_type !== 8'hF1) begin
         fails++; $display("FAIL basic_hdr: got start=%h type=%h, want 8000 F1", vz_start, vz_type);
      end
   endtask

   task automatic test_bad_magic();
      start_dl();
      send_hdr(32'h41424344, 8'hF1, 16'h8000);
      send_byte(16'd24, 8'h11, 1'b1);
      send_byte(16'd25, 8'h22, 1'b1);
      end_dl();
      tests++;
      if (wq.size() != 0) begin fails++; $display("FAIL magic_writes: got %0d writes, want 0", wq.size()); end
      tests++;
      if ({load_err, load_done} !== 2'b10) begin
         fails++; $display("FAIL magic_status: got err/done=%b, want 10", {load_err, load_done});
      end
   endtask

   task automatic test_patch();
      logic [23:0] exp [$];
      int hits;
      exp = '{24'h7AE901, 24'h7AEA02, 24'h7AEB03, 24'h7AEC04, 24'h7AED05};
`ifdef VZ_PATCH_EN
      exp.push_back(24'h78F9EE);
      exp.push_back(24'h78FA7A);
`endif
      start_dl();
      send_hdr(32'h20200000, 8'hF0, 16'h7AE9);
      for (int i = 0; i < 5; i++) send_byte(16'(24 + i), 8'(i + 1), 1'b1);
      end_dl();
      tests++;
      if (wq.size() != exp.size()) begin fails++; $display("FAIL patch_count: got %0d writes, want %0d", wq.size(), exp.size()); end
      else for (int i = 0; i < exp.size(); i++) begin
         tests++;
         if (wq[i] !== exp[i]) begin fails++; $display("FAIL patch_wr%0d: got %h, want %h", i, wq[i], exp[i]); end
      end
      hits = 0;
      foreach (wq[i]) if (wq[i][23:8] == 16'h78F9) hits++;
      tests++;
`ifdef VZ_PATCH_EN
      if (hits != 1) begin fails++; $display("FAIL patch_ptr: got %0d writes to 78F9, want 1", hits); end
`else
      if (hits != 0) begin fails++; $display("FAIL patch_ptr: got %0d writes to 78F9, want 0", hits); end
`endif
      tests++;
      if ({load_done, load_err} !== 2'b10) begin fails++; $display("FAIL patch_status: got done/err=%b, want 10", {load_done, load_err}); end
   endtask

   task automatic test_cpu_hold();
      logic [23:0] exp [$];
      exp = '{24'h900011, 24'h900122, 24'h900233, 24'h900344};
      start_dl();
      send_hdr(32'h565A4630, 8'hF1, 16'h9000);
      bad_we = 0;
      cpu_ram_req = 1'b1;
      send_byte(16'd24, 8'h11, 1'b0);
      send_byte(16'd25, 8'h22, 1'b0);
      send_byte(16'd26, 8'h33, 1'b0);
      tests++;
      if (dn_wait !== 1'b1) begin fails++; $display("FAIL hold_wait3: got dn_wait=%b at occupancy 3, want 1", dn_wait); end
      tests++;
      if (load_err !== 1'b0) begin fails++; $display("FAIL hold_err_pre: got %b, want 0", load_err); end
      send_byte(16'd27, 8'h44, 1'b0);
      send_byte(16'd28, 8'h55, 1'b0);   // FIFO full: dropped
      for (int i = 0; i < 5; i++) tick();
      tests++;
      if (wq.size() != 0 || bad_we != 0) begin
         fails++; $display("FAIL hold_nowrite: got %0d writes (%0d under cpu), want 0", wq.size(), bad_we);
      end
      tests++;
      if (load_err !== 1'b1) begin fails++; $display("FAIL hold_overflow: got load_err=%b, want 1", load_err); end
      cpu_ram_req = 1'b0;
      end_dl();
      tests++;
      if (wq.size() != exp.size()) begin fails++; $display("FAIL hold_count: got %0d writes, want %0d", wq.size(), exp.size()); end
      else for (int i = 0; i < exp.size(); i++) begin
         tests++;
         if (wq[i] !== exp[i]) begin fails++; $display("FAIL hold_wr%0d: got %h, want %h", i, wq[i], exp[i]); end
      end
      tests++;
      if (load_done !== 1'b1) begin fails++; $display("FAIL hold_done: got %b, want 1", load_done); end
   endtask

   task automatic test_wrap();
      logic [23:0] exp [$];
      exp = '{24'hFFFE10, 24'hFFFF20, 24'h000030, 24'h000140};
      start_dl();
      send_hdr(32'h565A4630, 8'hF1, 16'hFFFE);
      for (int i = 0; i < 4; i++) send_byte(16'(24 + i), 8'(16 * (i + 1)), 1'b1);
      end_dl();
      tests++;
      if (wq.size() != exp.size()) begin fails++; $display("FAIL wrap_count: got %0d writes, want %0d", wq.size(), exp.size()); end
      else for (int i = 0; i < exp.size(); i++) begin
         tests++;
         if (wq[i] !== exp[i]) begin fails++; $display("FAIL wrap_wr%0d: got %h, want %h", i, wq[i], exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] exp [$];
      exp = '{24'hB00001, 24'hB00102};
      start_dl();
      send_hdr(32'h565A4630, 8'hF1, 16'hA000);
      send_byte(16'd24, 8'h5A, 1'b1);
      send_byte(16'd25, 8'h5B, 1'b1);
      tests++;
      if (ram_we !== 1'b1) begin fails++; $display("FAIL rst_pre_we: got ram_we=%b two cycles after first byte, want 1", ram_we); end
      #20 rst_n = 1'b0;
      #1;
      tests++;
      if (ram_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b, want 0", ram_we); end
      tests++;
      if ({dn_wait, load_busy, load_done, load_err, ram_addr, ram_wdata, vz_type, vz_start} !== 52'h0) begin
         fails++; $display("FAIL rst_outs: got %h, want 0", {dn_wait, load_busy, load_done, load_err, ram_addr, ram_wdata, vz_type, vz_start});
      end
      dn_download = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      start_dl();
      send_hdr(32'h565A4630, 8'hF1, 16'hB000);
      send_byte(16'd24, 8'h01, 1'b1);
      send_byte(16'd25, 8'h02, 1'b1);
      end_dl();
      tests++;
      if (wq.size() != exp.size()) begin fails++; $display("FAIL rst_reload_count: got %0d writes, want %0d", wq.size(), exp.size()); end
      else for (int i = 0; i < exp.size(); i++) begin
         tests++;
         if (wq[i] !== exp[i]) begin fails++; $display("FAIL rst_reload_wr%0d: got %h, want %h", i, wq[i], exp[i]); end
      end
      tests++;
      if ({load_done, load_err} !== 2'b10) begin fails++; $display("FAIL rst_reload_status: got done/err=%b, want 10", {load_done, load_err}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_magic();
      test_patch();
      test_cpu_hold();
      test_wrap();
      test_reset_mid();
      tests++;
      if (bad_we != 0) begin fails++; $display("FAIL cpu_yield: got %0d writes under cpu_ram_req, want 0", bad_we); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
